edge_pixel_packer: RTL and testbench
====================================

# edge_pixel_packer

Sink-side block for the `edge_detection` output stream. Consumes the 2-bit classified pixel stream (`ready` / `out_pixel`), tracks row/column position within the cropped output frame, packs four pixels per byte and issues byte writes to an output frame memory. Sits between `edge_detection` and the frame buffer / host readback path, replacing the simulation-only hex dump with synthesizable capture.

## Interface

- `OUT_WIDTH`, 504: pixels per output line (input width minus 8-pixel border crop).
- `OUT_HEIGHT`, 504: lines per output frame.
- `ADDR_WIDTH`, 16: byte address width; must satisfy 2^ADDR_WIDTH ≥ ceil(OUT_WIDTH·OUT_HEIGHT/4).

- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous frame restart; aborts the current frame.
- `in_valid`  in  1  pixel strobe; driven by `edge_detection` `ready`.
- `in_pixel`  in  2  classified pixel; driven by `out_pixel` (00 none, 01 weak, 10 strong, 11 passed through unchanged).
- `out_we`  out  1  one-cycle byte write strobe.
- `out_addr`  out  ADDR_WIDTH  byte address for `out_we`.
- `out_data`  out  8  packed byte.
- `frame_done`  out  1  one-cycle pulse, coincident with the final write of a frame.
- `busy`  out  1  high while a frame is partially received.
- `col`  out  16  column of the next expected pixel.
- `row`  out  16  row of the next expected pixel.

## Operation

- States: IDLE (no pixels of the current frame received), ACTIVE (≥1 pixel received, frame incomplete).
- IDLE→ACTIVE on accepted `in_valid`; ACTIVE→IDLE on acceptance of pixel OUT_WIDTH·OUT_HEIGHT−1 or on `clear`.
- Packing: pixel i within a byte (i = 0..3, in arrival order) occupies `out_data[2i+1:2i]`; pixel 0 in LSBs.
- Byte emitted when the 4th pixel is accepted, or when the last pixel of the frame is accepted (partial byte, unused slots zero).
- `out_addr` starts at 0 per frame, increments by 1 after each write; no wrap within a frame.
- `col` increments per accepted pixel; at OUT_WIDTH−1 wraps to 0 and `row` increments; at frame end both return to 0.
- Pixels arriving after frame end automatically start the next frame at address 0.
- `clear` has priority over `in_valid`: coincident pixel discarded; pack register, `col`, `row`, address cleared; no write and no `frame_done` issued for the aborted frame.
- `busy` = state is ACTIVE.

## Timing

- Reset values: `out_we`=0, `out_addr`=0, `out_data`=0, `frame_done`=0, `busy`=0, `col`=0, `row`=0, state IDLE.
- Write latency: `out_we`/`out_addr`/`out_data` registered, valid the cycle after the completing pixel's `in_valid` cycle.
- `frame_done` asserted in the same cycle as the frame's final `out_we`.
- `col`/`row`/`busy` update the cycle after acceptance.
- No backpressure: one pixel per cycle at full rate must be accepted without loss.
- Reset mid-frame: all state lost immediately; no further writes for that frame.

## Configuration

- `EDGE_PACK_STATS_EN` defined: adds output `edge_count` [ADDR_WIDTH+1:0] = count of nonzero pixels in the last completed frame, latched in the `frame_done` cycle; internal counter cleared at frame start, on `clear`, and on reset (output reset 0, unchanged by `clear`).
- Not defined: no counter, no `edge_count` port.

## Test plan

- OUT_WIDTH=4, OUT_HEIGHT=2, pixels 1,2,3,0 then 0,0,0,2 back-to-back -> writes addr 0 data 0x39, addr 1 data 0x80; `frame_done` with second write; `busy` 0 afterward.
- OUT_WIDTH=3, OUT_HEIGHT=1, pixels 2,2,2 -> single write addr 0 data 0x2A, `frame_done` same cycle.
- Full-rate 504×504 frame of constant 01 -> 63504 writes, addresses 0..63503, every byte 0x55, one `frame_done`; second frame restarts at addr 0.
- `clear` asserted with `in_valid` after 6 pixels (4×2 frame) -> no write for pixel 6, `col`=`row`=0, next 8 pixels produce writes at addr 0,1.
- `rst_n` low mid-frame, then released -> all outputs 0, next pixel treated as frame pixel 0.
- With `EDGE_PACK_STATS_EN`, 4×2 frame pixels 1,0,2,0,3,0,0,1 -> `edge_count`=4 from `frame_done` cycle+1.

Source files
------------

// File: rtl/edge_pixel_packer.sv
// Packs the 2-bit classified edge pixel stream four-per-byte and issues byte writes to a frame memory.
// Optional EDGE_PACK_STATS_EN adds edge_count: nonzero pixels in the last completed frame.
module edge_pixel_packer #(
  parameter int OUT_WIDTH  = 504,
  parameter int OUT_HEIGHT = 504,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  in_valid,
  input  logic [1:0]            in_pixel,
  output logic                  out_we,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [7:0]            out_data,
  output logic                  frame_done,
  output logic                  busy,
  output logic [15:0]           col,
  output logic [15:0]           row
`ifdef EDGE_PACK_STATS_EN
  ,
  output logic [ADDR_WIDTH+1:0] edge_count
`endif
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  localparam logic [15:0] COL_LAST = 16'(OUT_WIDTH - 1);
  localparam logic [15:0] ROW_LAST = 16'(OUT_HEIGHT - 1);

  state_t                state;
  logic [7:0]            pack_p0;
  logic [1:0]            slot_p0;
  logic [ADDR_WIDTH-1:0] addr_p0;
  logic                  vld_p0;
  logic                  last_px;
  logic [7:0]            byte_nxt;

  function automatic logic [7:0] merge_pixel(input logic [7:0] pack,
                                             input logic [1:0] slot,
                                             input logic [1:0] pix);
    logic [7:0] b;
    b = pack;
    b[{slot, 1'b0} +: 2] = pix;
    return b;
  endfunction

  assign vld_p0   = in_valid & ~clear;
  assign last_px  = (col == COL_LAST) && (row == ROW_LAST);
  assign byte_nxt = merge_pixel(pack_p0, slot_p0, in_pixel);
  assign busy     = (state == ACTIVE);

  // Stage p0 -> p1: accept pixel, advance position, emit byte on 4th or final pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pack_p0    <= '0;
      slot_p0    <= '0;
      addr_p0    <= '0;
      col        <= '0;
      row        <= '0;
      out_we     <= 1'b0;
      out_addr   <= '0;
      out_data   <= '0;
      frame_done <= 1'b0;
    end else begin
      out_we     <= 1'b0;
      frame_done <= 1'b0;
      if (clear) begin
        state   <= IDLE;
        pack_p0 <= '0;
        slot_p0 <= '0;
        addr_p0 <= '0;
        col     <= '0;
        row     <= '0;
      end else if (vld_p0) begin
        if ((slot_p0 == 2'd3) || last_px) begin
          out_we   <= 1'b1;
          out_addr <= addr_p0;
          out_data <= byte_nxt;
          pack_p0  <= '0;
          slot_p0  <= '0;
          addr_p0  <= last_px ? '0 : addr_p0 + 1'b1;
        end else begin
          pack_p0 <= byte_nxt;
          slot_p0 <= slot_p0 + 1'b1;
        end
        if (last_px) begin
          state      <= IDLE;
          frame_done <= 1'b1;
          col        <= '0;
          row        <= '0;
        end else begin
          state <= ACTIVE;
          if (col == COL_LAST) begin
            col <= '0;
            row <= row + 16'd1;
          end else begin
            col <= col + 16'd1;
          end
        end
      end
    end
  end

`ifdef EDGE_PACK_STATS_EN
  logic [ADDR_WIDTH+1:0] cnt_p0;
  logic [ADDR_WIDTH+1:0] cnt_nxt;

  // The running count restarts with each frame; the output holds until the next frame completes
  assign cnt_nxt = cnt_p0 + {{(ADDR_WIDTH+1){1'b0}}, (in_pixel != 2'b00)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_p0     <= '0;
      edge_count <= '0;
    end else if (clear) begin
      cnt_p0 <= '0;
    end else if (vld_p0) begin
      if (last_px) begin
        cnt_p0     <= '0;
        edge_count <= cnt_nxt;
      end else begin
        cnt_p0 <= cnt_nxt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_edge_pixel_packer.sv
// Scoreboard bench for edge_pixel_packer on a small 6x3 frame with randomized valid/clear/pixels.
module tb_edge_pixel_packer;
  localparam int W  = 6;
  localparam int H  = 3;
  localparam int AW = 4;
  localparam int N  = W * H;

  logic          clk;
  logic          rst_n;
  logic          clear;
  logic          in_valid;
  logic [1:0]    in_pixel;
  logic          out_we;
  logic [AW-1:0] out_addr;
  logic [7:0]    out_data;
  logic          frame_done;
  logic          busy;
  logic [15:0]   col;
  logic [15:0]   row;
`ifdef EDGE_PACK_STATS_EN
  logic [AW+1:0] edge_count;
`endif

  edge_pixel_packer #(.OUT_WIDTH(W), .OUT_HEIGHT(H), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_pixel(in_pixel),
    .out_we(out_we), .out_addr(out_addr), .out_data(out_data), .frame_done(frame_done),
    .busy(busy), .col(col), .row(row)
`ifdef EDGE_PACK_STATS_EN
    , .edge_count(edge_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Reference model: frame pixel index p, byte address p/4, slot p%4
  typedef struct {int addr; int data; bit done;} wr_t;
  wr_t  q[$];
  int   p = 0;
  int   acc = 0;
  int   cnt = 0;
  int   exp_edge = 0;
  bit   exp_we = 0;
  bit   exp_done = 0;
  int   wr_seen = 0;
  int   last_data = 0;

  task automatic model_reset();
    p = 0; acc = 0; cnt = 0; exp_edge = 0; exp_we = 0; exp_done = 0;
    q.delete();
  endtask

  task automatic model_step(input bit v, input int px, input bit clr);
    exp_we = 0;
    exp_done = 0;
    if (clr) begin
      p = 0; acc = 0; cnt = 0;
    end else if (v) begin
      acc = acc + (px << (2 * (p % 4)));
      if (px != 0) cnt++;
      if ((p % 4 == 3) || (p == N - 1)) begin
        wr_t w;
        w.addr = p / 4;
        w.data = acc;
        w.done = (p == N - 1);
        q.push_back(w);
        exp_we = 1;
        exp_done = w.done;
        acc = 0;
      end
      if (p == N - 1) begin
        p = 0;
        exp_edge = cnt;
        cnt = 0;
      end else begin
        p++;
      end
    end
  endtask

  task automatic cycle(input bit v, input logic [1:0] px, input bit clr);
    in_valid = v; in_pixel = px; clear = clr;
    @(posedge clk);
    model_step(v, int'(px), clr);
    #1;
  endtask

  // Monitor: compares every cycle away from the active edge
  always @(negedge clk) begin
    if (rst_n) begin
      check("out_we", out_we, exp_we);
      check("frame_done", frame_done, exp_done);
      check("col", col, p % W);
      check("row", row, p / W);
      check("busy", busy, p != 0);
`ifdef EDGE_PACK_STATS_EN
      if (!frame_done) check("edge_count", edge_count, exp_edge);
`endif
      if (out_we) begin
        wr_seen++;
        last_data = int'(out_data);
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: addr %0d data 0x%0h with empty scoreboard", out_addr, out_data);
        end else begin
          wr_t w;
          w = q.pop_front();
          check("out_addr", out_addr, w.addr);
          check("out_data", out_data, w.data);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_pixel = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_we", out_we, 0);
    check("rst_out_addr", out_addr, 0);
    check("rst_out_data", out_data, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_busy", busy, 0);
    check("rst_col", col, 0);
    check("rst_row", row, 0);
    rst_n = 1'b1;

    // Full-rate constant 01 frame: five bytes, last one partial (two pixels)
    wr_seen = 0;
    for (int i = 0; i < N; i++) cycle(1'b1, 2'b01, 1'b0);
    cycle(1'b0, 2'b00, 1'b0);
    cycle(1'b0, 2'b00, 1'b0);
    check("const_frame_writes", wr_seen, 5);
    check("const_frame_last_byte", last_data, 32'h05);
    check("const_frame_idle", busy, 0);

    // Known pattern then second frame restarting at address 0
    for (int i = 0; i < N; i++) cycle(1'b1, 2'(i % 4 + 1), 1'b0);

    // Clear coincident with a pixel after six pixels
    for (int i = 0; i < 6; i++) cycle(1'b1, 2'(i), 1'b0);
    cycle(1'b1, 2'b10, 1'b1);
    cycle(1'b0, 2'b00, 1'b0);
    check("clear_col", col, 0);
    check("clear_row", row, 0);
    for (int i = 0; i < 8; i++) cycle(1'b1, 2'b11, 1'b0);

    // Randomized traffic with occasional clears and idle gaps
    for (int i = 0; i < 3000; i++)
      cycle(($urandom % 5) != 0, 2'($urandom), ($urandom % 64) == 0);

    // Asynchronous reset in the middle of a frame
    for (int i = 0; i < 7; i++) cycle(1'b1, 2'b10, 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_we", out_we, 0);
    check("midrst_out_addr", out_addr, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_busy", busy, 0);
    check("midrst_col", col, 0);
    check("midrst_row", row, 0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < N + 3; i++) cycle(1'b1, 2'($urandom), 1'b0);

    repeat (3) cycle(1'b0, 2'b00, 1'b0);
    check("scoreboard_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
